// File: rtl/status_pkg.sv
// Shared definitions for the status flag / condition unit: flag layout,
// condition encodings and the flag vector type.
package status_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;
    typedef logic [COND_W-1:0] cond_t;

    localparam cond_t COND_EQ = 4'd0;
    localparam cond_t COND_NE = 4'd1;
    localparam cond_t COND_CS = 4'd2;
    localparam cond_t COND_CC = 4'd3;
    localparam cond_t COND_MI = 4'd4;
    localparam cond_t COND_PL = 4'd5;
    localparam cond_t COND_VS = 4'd6;
    localparam cond_t COND_VC = 4'd7;
    localparam cond_t COND_HI = 4'd8;
    localparam cond_t COND_LS = 4'd9;
    localparam cond_t COND_GE = 4'd10;
    localparam cond_t COND_LT = 4'd11;
    localparam cond_t COND_GT = 4'd12;
    localparam cond_t COND_LE = 4'd13;
    localparam cond_t COND_AL = 4'd14;
    localparam cond_t COND_NV = 4'd15;

endpackage

// File: rtl/status_cond_unit_cond_eval.sv
// Combinational condition-field evaluator against an {N,Z,C,V} flag vector.
// Stateless so it can be shared with other consumers such as a branch predictor.
module cond_eval
    import status_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// Status flag register with shadow copy and registered condition check.
// Optional FLAG_BYPASS_EN: evaluate against same-cycle ALU/shadow flags.
module status_cond_unit
    import status_pkg::*;
#(
    parameter flags_t RESET_FLAGS  = 4'b0000,
    parameter flags_t RESET_SHADOW = 4'b0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              flags_we,
    input  logic              save_en,
    input  logic              restore_en,
    input  logic              cond_valid,
    input  logic [COND_W-1:0] cond,
    output logic              cond_ready,
    output logic              cond_out_valid,
    output logic              cond_true,
    output logic [FLAG_W-1:0] flags
);

    flags_t r_flags;
    flags_t r_shadow;
    logic   r_ready;
    logic   r_out_valid;
    logic   r_cond_true;

    flags_t w_alu_flags;
    flags_t w_eval_flags;
    logic   w_accept;
    logic   w_pass;

    assign w_alu_flags = {alu_n, alu_z, alu_c, alu_v};
    assign w_accept    = cond_valid && r_ready;

`ifdef FLAG_BYPASS_EN
    // Forward the value the flag register is about to take
    assign w_eval_flags = restore_en ? r_shadow
                        : flags_we   ? w_alu_flags
                        : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (w_eval_flags),
        .pass  (w_pass)
    );

    // Restore beats an ALU write; save always samples the pre-edge flags,
    // which makes save+restore a one-edge swap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags     <= RESET_FLAGS;
            r_shadow    <= RESET_SHADOW;
            r_ready     <= 1'b0;
            r_out_valid <= 1'b0;
            r_cond_true <= 1'b0;
        end else begin
            if (restore_en) begin
                r_flags <= r_shadow;
            end else if (flags_we) begin
                r_flags <= w_alu_flags;
            end
            if (save_en) begin
                r_shadow <= r_flags;
            end
            r_ready     <= 1'b1;
            r_out_valid <= w_accept;
            r_cond_true <= w_accept && w_pass;
        end
    end

    assign cond_ready     = r_ready;
    assign cond_out_valid = r_out_valid;
    assign cond_true      = r_cond_true;
    assign flags          = r_flags;

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed self-checking bench for status_cond_unit; expectations follow
// FLAG_BYPASS_EN when the bench is built with it.
module tb_status_cond_unit;

    logic       clk;
    logic       reset_n;
    logic       alu_n;
    logic       alu_z;
    logic       alu_c;
    logic       alu_v;
    logic       flags_we;
    logic       save_en;
    logic       restore_en;
    logic       cond_valid;
    logic [3:0] cond;
    logic       cond_ready;
    logic       cond_out_valid;
    logic       cond_true;
    logic [3:0] flags;

    int errors = 0;
    int checks = 0;

    status_cond_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_n          (alu_n),
        .alu_z          (alu_z),
        .alu_c          (alu_c),
        .alu_v          (alu_v),
        .flags_we       (flags_we),
        .save_en        (save_en),
        .restore_en     (restore_en),
        .cond_valid     (cond_valid),
        .cond           (cond),
        .cond_ready     (cond_ready),
        .cond_out_valid (cond_out_valid),
        .cond_true      (cond_true),
        .flags          (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic load_flags(input logic [3:0] f);
        set_alu(f);
        flags_we = 1'b1;
        tick();
        flags_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flags_we = 1'b1;
        set_alu(4'b1111);
        tick();
        tick();
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", flags);
        end
        checks++;
        if (cond_out_valid !== 1'b0 || cond_true !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b true=%b want 0/0", cond_out_valid, cond_true);
        end
        checks++;
        if (cond_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", cond_ready);
        end
        reset_n = 1'b1;
        flags_we = 1'b0;
        tick();
        checks++;
        if (cond_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", cond_ready);
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL flags_after_reset: got %b want 0000", flags);
        end
    endtask

    task automatic test_load_gt();
        load_flags(4'b0010);
        checks++;
        if (flags !== 4'b0010) begin
            errors++;
            $display("FAIL load_flags: got %b want 0010", flags);
        end
        cond_valid = 1'b1;
        cond = 4'd12;
        tick();
        cond_valid = 1'b0;
        checks++;
        if (cond_out_valid !== 1'b1 || cond_true !== 1'b1) begin
            errors++;
            $display("FAIL gt_pass: got valid=%b true=%b want 1/1", cond_out_valid, cond_true);
        end
        load_flags(4'b0110);
        cond_valid = 1'b1;
        cond = 4'd12;
        tick();
        cond_valid = 1'b0;
        checks++;
        if (cond_out_valid !== 1'b1 || cond_true !== 1'b0) begin
            errors++;
            $display("FAIL gt_fail_z: got valid=%b true=%b want 1/0", cond_out_valid, cond_true);
        end
        cond = 4'd14;
        tick();
        checks++;
        if (cond_out_valid !== 1'b0 || cond_true !== 1'b0) begin
            errors++;
            $display("FAIL idle_out: got valid=%b true=%b want 0/0", cond_out_valid, cond_true);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pattern;
        pattern = 16'b0101_0110_0101_1010;
        load_flags(4'b1001);
        cond_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            tick();
            checks++;
            if (cond_out_valid !== 1'b1 || cond_true !== pattern[i]) begin
                errors++;
                $display("FAIL sweep_cond%0d: got valid=%b true=%b want 1/%b",
                         i, cond_out_valid, cond_true, pattern[i]);
            end
        end
        cond_valid = 1'b0;
        tick();
    endtask

    task automatic test_save_restore();
        load_flags(4'b0100);
        save_en = 1'b1;
        tick();
        save_en = 1'b0;
        load_flags(4'b1010);
        checks++;
        if (flags !== 4'b1010) begin
            errors++;
            $display("FAIL load_1010: got %b want 1010", flags);
        end
        restore_en = 1'b1;
        tick();
        restore_en = 1'b0;
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL restore: got %b want 0100", flags);
        end
        load_flags(4'b0001);
        save_en = 1'b1;
        restore_en = 1'b1;
        tick();
        save_en = 1'b0;
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL swap_flags: got %b want 0100", flags);
        end
        tick();
        restore_en = 1'b0;
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL swap_shadow: got %b want 0001", flags);
        end
        // restore beats an ALU write in the same cycle
        set_alu(4'b1111);
        flags_we = 1'b1;
        restore_en = 1'b1;
        tick();
        flags_we = 1'b0;
        restore_en = 1'b0;
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL restore_over_we: got %b want 0001", flags);
        end
        load_flags(4'b0110);
        set_alu(4'b1000);
        flags_we = 1'b1;
        save_en = 1'b1;
        tick();
        flags_we = 1'b0;
        save_en = 1'b0;
        checks++;
        if (flags !== 4'b1000) begin
            errors++;
            $display("FAIL save_with_we: got %b want 1000", flags);
        end
        restore_en = 1'b1;
        tick();
        restore_en = 1'b0;
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL save_old_flags: got %b want 0110", flags);
        end
    endtask

    task automatic test_hazard();
        logic exp_we;
        logic exp_rs;
`ifdef FLAG_BYPASS_EN
        exp_we = 1'b1;
        exp_rs = 1'b0;
`else
        exp_we = 1'b0;
        exp_rs = 1'b1;
`endif
        load_flags(4'b0000);
        set_alu(4'b0100);
        flags_we = 1'b1;
        cond_valid = 1'b1;
        cond = 4'd0;
        tick();
        flags_we = 1'b0;
        checks++;
        if (cond_out_valid !== 1'b1 || cond_true !== exp_we) begin
            errors++;
            $display("FAIL hazard_we: got valid=%b true=%b want 1/%b", cond_out_valid, cond_true, exp_we);
        end
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL hazard_flags: got %b want 0100", flags);
        end
        // flags=0100, shadow=0110: restore in the request cycle
        load_flags(4'b0110);
        save_en = 1'b1;
        cond_valid = 1'b0;
        tick();
        save_en = 1'b0;
        load_flags(4'b0100);
        set_alu(4'b0100);
        flags_we = 1'b1;
        restore_en = 1'b1;
        cond_valid = 1'b1;
        cond = 4'd3;
        tick();
        flags_we = 1'b0;
        restore_en = 1'b0;
        checks++;
        if (cond_out_valid !== 1'b1 || cond_true !== exp_rs) begin
            errors++;
            $display("FAIL hazard_restore: got valid=%b true=%b want 1/%b", cond_out_valid, cond_true, exp_rs);
        end
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL hazard_restore_flags: got %b want 0110", flags);
        end
        // request pending at the edge where reset hits is dropped
        cond = 4'd14;
        reset_n = 1'b0;
        tick();
        checks++;
        if (cond_out_valid !== 1'b0 || cond_true !== 1'b0 || cond_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: got valid=%b true=%b ready=%b want 0/0/0",
                     cond_out_valid, cond_true, cond_ready);
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_flags: got %b want 0000", flags);
        end
        cond_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (cond_out_valid !== 1'b0 || cond_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b want 0/1", cond_out_valid, cond_ready);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_alu(4'b0000);
        flags_we = 1'b0;
        save_en = 1'b0;
        restore_en = 1'b0;
        cond_valid = 1'b0;
        cond = 4'd0;
        test_reset();
        test_load_gt();
        test_back_to_back();
        test_save_restore();
        test_hazard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
